// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read data memory between the core and the host/debug port.
// Optional statistics counters are built when MEM_PORT_ARB_STATS_EN is defined.
module mem_port_arbiter #(
    parameter int WORD           = 32,
    parameter int ADDR_W         = 8,
    parameter int HOST_BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [WORD-1:0]   core_wdata,
    output logic              core_stall,
    output logic [WORD-1:0]   core_rdata,
    output logic              core_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [WORD-1:0]   host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic [WORD-1:0]   host_rdata,
    output logic              host_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD-1:0]   mem_wdata,
    input  logic [WORD-1:0]   mem_rdata,
    output logic [31:0]       stat_core_stall_cnt,
    output logic [31:0]       stat_host_gnt_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CORE = 2'd1;
    localparam logic [1:0] HOST = 2'd2;
    localparam logic [7:0] BURST_MAX = 8'(HOST_BURST_MAX);

    logic [1:0] owner_q, owner_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       rd_core_q, rd_core_d;
    logic       rd_host_q, rd_host_d;
    logic       core_gnt;
    logic       lock_hold;

    // State register; reset leaves owner=HOST so the core wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= HOST;
            burst_cnt_q <= '0;
            rd_core_q   <= 1'b0;
            rd_host_q   <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_core_q   <= rd_core_d;
            rd_host_q   <= rd_host_d;
        end
    end

    // Next state: remember the winner, count locked host grants, flag pending reads.
    always_comb begin
        owner_d     = host_gnt ? HOST : (core_gnt ? CORE : IDLE);
        burst_cnt_d = host_gnt ? ((burst_cnt_q == BURST_MAX) ? burst_cnt_q : burst_cnt_q + 8'd1) : 8'd0;
        rd_core_d   = core_gnt & ~core_we;
        rd_host_d   = host_gnt & ~host_we;
    end

    // Grant decision and memory steering; a locked host keeps ownership until the burst limit.
    always_comb begin
        lock_hold   = host_lock && (owner_q == HOST) && (burst_cnt_q < BURST_MAX);
        host_gnt    = host_req && (!core_req || lock_hold || (owner_q == CORE));
        core_gnt    = core_req && !host_gnt;
        core_stall  = core_req && !core_gnt;
        mem_en      = core_gnt | host_gnt;
        mem_we      = host_gnt ? host_we : (core_gnt ? core_we : 1'b0);
        mem_addr    = host_gnt ? host_addr : (core_gnt ? core_addr : '0);
        mem_wdata   = host_gnt ? host_wdata : (core_gnt ? core_wdata : '0);
        core_rvalid = rd_core_q;
        host_rvalid = rd_host_q;
        core_rdata  = rd_core_q ? mem_rdata : '0;
        host_rdata  = rd_host_q ? mem_rdata : '0;
    end

`ifdef MEM_PORT_ARB_STATS_EN
    logic [31:0] stat_core_stall_cnt_q, stat_core_stall_cnt_d;
    logic [31:0] stat_host_gnt_cnt_q, stat_host_gnt_cnt_d;

    // Statistics increment; both counters wrap naturally at 32 bits.
    always_comb begin
        stat_core_stall_cnt_d = stat_core_stall_cnt_q + 32'(core_stall);
        stat_host_gnt_cnt_d   = stat_host_gnt_cnt_q + 32'(host_gnt);
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_core_stall_cnt_q <= '0;
            stat_host_gnt_cnt_q   <= '0;
        end else begin
            stat_core_stall_cnt_q <= stat_core_stall_cnt_d;
            stat_host_gnt_cnt_q   <= stat_host_gnt_cnt_d;
        end
    end

    assign stat_core_stall_cnt = stat_core_stall_cnt_q;
    assign stat_host_gnt_cnt   = stat_host_gnt_cnt_q;
`else
    assign stat_core_stall_cnt = 32'd0;
    assign stat_host_gnt_cnt   = 32'd0;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data memory (256 x WORD, synchronous read) between two requesters: the core load/store path and the host/debug port.
- The host/debug port is used for program/data preload and for result readback while the core runs.
- Sits between the core, the host interface and mem_rw. It arbitrates every cycle, steers address, data and write-enable to the memory, and routes read data back to the requester that was granted.
- Produces the core stall when the core loses arbitration.

Parameters:
- WORD, 32, data width.
- ADDR_W, 8, memory word-address width.
- HOST_BURST_MAX, 16, maximum consecutive locked host grants before one forced core slot (range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core memory access request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  WORD  core write data.
- core_stall  out  1  core request present but not granted this cycle.
- core_rdata  out  WORD  read data returned to the core.
- core_rvalid  out  1  core read data valid; one-cycle pulse.
- host_req  in  1  host access request.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host word address.
- host_wdata  in  WORD  host write data.
- host_lock  in  1  host requests back-to-back ownership (block transfer).
- host_gnt  out  1  host access performed this cycle.
- host_rdata  out  WORD  read data returned to the host.
- host_rvalid  out  1  host read data valid; one-cycle pulse.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  WORD  memory write data.
- mem_rdata  in  WORD  memory read data, valid one cycle after mem_en with mem_we=0.
- stat_core_stall_cnt  out  32  statistics counter (see Optional Feature).
- stat_host_gnt_cnt  out  32  statistics counter (see Optional Feature).

Behaviour:
- State register `owner` holds the previous cycle's grant: IDLE, CORE or HOST. Reset value: HOST, so the core wins the first tie.
- Counters and response flags:
  - burst_cnt (8 bit): consecutive host grants. Cleared by any core grant or any cycle with no grant.
  - rd_core, rd_host: pending-read flags.
  - Reset value of all of these: 0.
- Grant decision is combinational from the inputs and the registered state:
  - Only one requester active: that requester is granted.
  - Both requesting, host_lock=1, owner=HOST, burst_cnt<HOST_BURST_MAX: host is granted.
  - Both requesting, otherwise: round-robin. Grant goes to the requester that is not `owner`; if owner=IDLE, the core is granted.
  - Neither requesting: no grant, and owner becomes IDLE next cycle.
- On each rising edge:
  - owner is updated to the granted requester.
  - burst_cnt is incremented on a host grant and saturates at HOST_BURST_MAX.
  - A forced core grant (lock active, limit reached) clears burst_cnt, so the host may lock again for HOST_BURST_MAX cycles.
- Memory outputs:
  - mem_en = core_gnt | host_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted requester.
  - All are 0 when there is no grant.
- Status outputs:
  - core_stall = core_req & ~core_gnt.
  - host_gnt = host grant; the host must hold its request stable until host_gnt.
- Read return path:
  - rd_core <= core_gnt & ~core_we; rd_host <= host_gnt & ~host_we.
  - core_rvalid = rd_core and host_rvalid = rd_host.
  - core_rdata = mem_rdata when rd_core, else 0; host_rdata likewise.
  - Latency: 1 cycle from grant to rvalid.
  - Reads and writes may be granted back-to-back with no bubble.
- Write-then-read to the same address on consecutive grants returns the new data (memory write-first ordering is already provided by mem_rw).
- Writes produce no rvalid.
- Reset mid-operation:
  - All registers clear immediately (asynchronous).
  - A pending read response is dropped; no rvalid is produced after reset.
  - Combinational outputs follow the inputs once reset deasserts.

Optional Feature:
- Macro: MEM_PORT_ARB_STATS_EN.
- When defined:
  - stat_core_stall_cnt increments every cycle core_stall=1.
  - stat_host_gnt_cnt increments every cycle host_gnt=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- When undefined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Core read only, memory holds 0xDEADBEEF at 0x10, core_req with addr 0x10 -> mem_en=1 with core_stall=0 the same cycle; next cycle core_rvalid=1 and core_rdata=0xDEADBEEF; host_rvalid=0.
- Both requesting reads continuously for 4 cycles, host_lock=0, after reset -> grants core, host, core, host; core_stall=0,1,0,1; rvalid pulses alternate, one cycle later.
- HOST_BURST_MAX=4, host holds a granted locked burst, core_req asserted on the next cycle and held -> host granted 4 consecutive cycles, core granted 1, host 4 more; burst_cnt never exceeds 4.
- Host writes 0x00000005 to 0x20, next cycle core reads 0x20 -> core_rdata=0x00000005 with core_rvalid one cycle after the core grant; no rvalid for the write.
- Core read granted, reset asserted before the next edge -> core_rvalid stays 0; after release with both requesting, the core is granted first (owner=HOST at reset).
- With MEM_PORT_ARB_STATS_EN, 10 cycles of both requesting, no lock -> stat_core_stall_cnt=5 and stat_host_gnt_cnt=5. Without the macro -> both read 0.
